sync_fifo: RTL
==============

// Module: sync_fifo
// PURPOSE
//   Single-clock parametrised FIFO. Next generation of the serial-link buffering: N-bit data
//   instead of 1-bit, power-of-2 depth, almost-full/almost-empty thresholds, fill count,
//   sticky overflow/underflow error flags and a selectable first-word-fall-through read mode.
//   Sits between the deserialiser word assembler and downstream consumers in the same domain.
// PARAMETERS
//   WIDTH      8            data word width in bits (>=1)
//   DEPTH      16           number of entries; power of 2, >=2
//   PTR_WIDTH  $clog2(DEPTH) address width; pointers are PTR_WIDTH+1 bits (wrap bit)
//   AF_THRESH  DEPTH-2      o_almost_full asserted when count >= AF_THRESH
//   AE_THRESH  2            o_almost_empty asserted when count <= AE_THRESH
//   FWFT       0            0 = registered read, 1 = first-word-fall-through
// PORTS
//   i_Clk          in   1            clock, all logic on rising edge
//   i_Rst_n        in   1            reset, synchronous, active-low
//   i_W_en         in   1            write request
//   i_Data_In      in   WIDTH        write data
//   i_R_en         in   1            read request
//   i_Clr_flags    in   1            clears o_overflow/o_underflow
//   o_Data_Out     out  WIDTH        read data
//   o_Valid        out  1            o_Data_Out holds a freshly read word (FWFT=0 only)
//   o_full         out  1            count == DEPTH
//   o_empty        out  1            count == 0
//   o_almost_full  out  1            count >= AF_THRESH
//   o_almost_empty out  1            count <= AE_THRESH
//   o_count        out  PTR_WIDTH+1  current fill level, 0..DEPTH
//   o_overflow     out  1            sticky: write attempted while full
//   o_underflow    out  1            sticky: read attempted while empty
// BEHAVIOUR
//   Reset (i_Rst_n=0 at edge): wptr=rptr=0, count=0, o_Data_Out=0, o_Valid=0, overflow=
//     underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).
//     Memory contents not cleared. Reset mid-operation discards all entries; reset wins
//     over any concurrent W/R request.
//   Accept rules: write accepted = i_W_en & !o_full; read accepted = i_R_en & !o_empty.
//     Flags evaluated from registered state before the edge; a write while full is rejected
//     even if a read is accepted the same cycle; a read while empty is rejected even if a
//     write is accepted the same cycle.
//   Accepted write: mem[wptr[PTR_WIDTH-1:0]] <= i_Data_In, wptr+1 (mod 2^(PTR_WIDTH+1)).
//   Accepted read: rptr+1 (mod 2^(PTR_WIDTH+1)).
//   count: +1 write only, -1 read only, unchanged on both or neither. count == wptr-rptr.
//   All status outputs are combinational decodes of registered count: reflect an accepted
//     operation on the cycle after its edge. full <=> wptr/rptr differ only in MSB.
//   Errors: i_W_en & o_full sets o_overflow; i_R_en & o_empty sets o_underflow. Sticky
//     until i_Clr_flags=1; set condition wins over clear in the same cycle.
//   FWFT=0: on accepted read, o_Data_Out <= mem[rptr] at that edge (latency 1), o_Valid=1
//     for exactly that following cycle, else 0. o_Data_Out holds last value otherwise.
//   FWFT=1: o_Data_Out = mem[rptr] combinationally whenever !o_empty (head visible, 0
//     latency); i_R_en pops it. o_Data_Out = 0 when empty; o_Valid tied to !o_empty.
//   Simultaneous W/R when empty (FWFT=1): write accepted, read rejected + underflow set.
// TESTING
//   1 Reset, then write 16 words 0x00..0x0F (DEPTH=16) -> full=1 after 16th, count=16,
//     almost_full from count=14, no overflow; 17th write -> overflow=1, count stays 16.
//   2 Read 16 words (FWFT=0) -> o_Data_Out 0x00..0x0F, each 1 cycle after i_R_en with
//     o_Valid=1; empty=1 after last; extra read -> underflow=1, o_Valid=0.
//   3 Half full (8), assert W and R together 20 cycles -> count stays 8, data order kept
//     across pointer wrap (writes 0x10..0x23 read back in order).
//   4 FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0, o_Data_Out=0xA5 before
//     any read; pop -> empty=1, o_Data_Out=0.
//   5 Set overflow, pulse i_Clr_flags with no write -> cleared; clear+overflowing write
//     same cycle -> flag stays 1.
//   6 Fill to 10, assert i_Rst_n=0 one cycle with W/R high -> count=0, empty=1, all
//     flags/outputs at reset values; subsequent write/read returns new data only.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a registered or first-word-fall-through read path.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_W_en,
  input  logic [WIDTH-1:0]     i_Data_In,
  input  logic                 i_R_en,
  input  logic                 i_Clr_flags,
  output logic [WIDTH-1:0]     o_Data_Out,
  output logic                 o_Valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [PTR_WIDTH:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] PTR_ONE = CW'(1);
  localparam logic [CW-1:0] AF_CNT  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT  = CW'(AE_THRESH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [CW-1:0]        wptr;
  logic [CW-1:0]        rptr;
  logic [CW-1:0]        count;
  logic [PTR_WIDTH-1:0] waddr;
  logic [PTR_WIDTH-1:0] raddr;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 ovf_q;
  logic                 unf_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign waddr = wptr[PTR_WIDTH-1:0];
  assign raddr = rptr[PTR_WIDTH-1:0];
  assign count = wptr - rptr;

  assign o_full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) && (waddr == raddr);
  assign o_empty        = (wptr == rptr);
  assign o_almost_full  = (count >= AF_CNT);
  assign o_almost_empty = (count <= AE_CNT);
  assign o_count        = count;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

  assign wr_acc = i_W_en & ~o_full;
  assign rd_acc = i_R_en & ~o_empty;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge i_Clk) begin
    if (i_Rst_n && wr_acc) mem[waddr] <= i_Data_In;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_W_en && o_full)    ovf_q <= 1'b1;
      else if (i_Clr_flags)    ovf_q <= 1'b0;
      if (i_R_en && o_empty)   unf_q <= 1'b1;
      else if (i_Clr_flags)    unf_q <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_Data_Out = o_empty ? '0 : mem[raddr];
      assign o_Valid    = ~o_empty;
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) data_q <= mem[raddr];
        end
      end

      assign o_Data_Out = data_q;
      assign o_Valid    = valid_q;
    end
  endgenerate

endmodule
